// File: rtl/mx_pkt_tx_mux.sv
// Purpose: arbitrates CH_NUM packet streams onto one tx stream, whole packets at a time.
// Latency: 1 cycle from an accepted input word to tx_val_o; one idle cycle between packets.
// Backpressure: granted channel sees ready only while the output register is empty or draining.
module mx_pkt_tx_mux #(
  parameter int    CH_NUM   = 2,
  parameter int    DATA_W   = 64,
  parameter int    EMPTY_W  = $clog2(DATA_W/8),
  parameter string ARB_MODE = "RR",
  parameter int    CNT_W    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [CH_NUM*DATA_W-1:0]    ch_data_i,
  input  logic [CH_NUM-1:0]           ch_sop_i,
  input  logic [CH_NUM-1:0]           ch_eop_i,
  input  logic [CH_NUM-1:0]           ch_val_i,
  input  logic [CH_NUM*EMPTY_W-1:0]   ch_empty_i,
  output logic [CH_NUM-1:0]           ch_ready_o,
  input  logic [CH_NUM-1:0]           ch_en_i,
  output logic [DATA_W-1:0]           tx_data_o,
  output logic [EMPTY_W-1:0]          tx_empty_o,
  output logic                        tx_sop_o,
  output logic                        tx_eop_o,
  output logic                        tx_val_o,
  input  logic                        tx_ready_i,
  input  logic                        cnt_clr_i,
  output logic [CH_NUM*CNT_W-1:0]     pkt_cnt_o,
  output logic [CNT_W-1:0]            drop_cnt_o,
  output logic [$clog2(CH_NUM)-1:0]   cur_ch_o,
  output logic                        busy_o
);

  localparam int CH_W = $clog2(CH_NUM);
  localparam bit PRIO = (ARB_MODE == "PRIO");
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     grant, last_grant, pick;
  logic [CH_NUM-1:0]   elig, orphan;
  logic                any_elig;
  logic                acc, acc_eop;
  logic [3:0]          drop_n;
  logic [CNT_W+3:0]    drop_sum;
  logic [CNT_W-1:0]    pkt_cnt [CH_NUM];

  // Channels that may start a packet, and enabled channels offering a word outside a packet.
  assign elig     = ch_val_i & ch_sop_i & ch_en_i;
  assign orphan   = ch_val_i & ~ch_sop_i & ch_en_i;
  assign any_elig = |elig;

  // Arbiter: lowest index in PRIO mode, otherwise first eligible channel after last_grant.
  always_comb begin
    logic found;
    int   idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    if (PRIO) begin
      for (int i = CH_NUM-1; i >= 0; i--) begin
        if (elig[CH_W'(i)]) pick = CH_W'(i);
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        idx = (int'(last_grant) + 1 + i) % CH_NUM;
        if (!found && elig[CH_W'(idx)]) begin
          pick  = CH_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  // Ready: orphans are drained in IDLE; in PKT only the granted channel, gated by the output register.
  always_comb begin
    ch_ready_o = '0;
    if (rst_n_i) begin
      if (state == S_IDLE) ch_ready_o = orphan;
      else                 ch_ready_o[grant] = !tx_val_o || tx_ready_i;
    end
  end

  assign acc     = (state == S_PKT) && ch_val_i[grant] && ch_ready_o[grant];
  assign acc_eop = acc && ch_eop_i[grant];

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state: enter PKT on any eligible start, leave on the granted channel's eop transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_elig) state_nxt = S_PKT;
      S_PKT:   if (acc_eop)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs derived from the state and the current grant.
  always_comb begin
    busy_o   = (state == S_PKT);
    cur_ch_o = grant;
  end

  // Grant latch; last_grant steers the round-robin search.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      grant      <= '0;
      last_grant <= CH_W'(CH_NUM-1);
    end else if (state == S_IDLE && any_elig) begin
      grant      <= pick;
      last_grant <= pick;
    end
  end

  // Output register: load on accept, drop valid once the downstream takes the word.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_data_o  <= '0;
      tx_empty_o <= '0;
      tx_sop_o   <= 1'b0;
      tx_eop_o   <= 1'b0;
      tx_val_o   <= 1'b0;
    end else if (acc) begin
      tx_data_o  <= ch_data_i[grant*DATA_W +: DATA_W];
      tx_empty_o <= ch_empty_i[grant*EMPTY_W +: EMPTY_W];
      tx_sop_o   <= ch_sop_i[grant];
      tx_eop_o   <= ch_eop_i[grant];
      tx_val_o   <= 1'b1;
    end else if (tx_ready_i) begin
      tx_val_o   <= 1'b0;
    end
  end

  // Orphan words dropped this cycle, added with headroom so saturation can be detected.
  always_comb begin
    drop_n   = (state == S_IDLE) ? 4'($countones(orphan)) : 4'd0;
    drop_sum = {4'd0, drop_cnt_o} + (CNT_W+4)'(drop_n);
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || cnt_clr_i) begin
      drop_cnt_o <= '0;
      for (int k = 0; k < CH_NUM; k++) pkt_cnt[k] <= '0;
    end else begin
      if (drop_sum > {4'd0, CNT_MAX}) drop_cnt_o <= CNT_MAX;
      else                            drop_cnt_o <= drop_sum[CNT_W-1:0];
      for (int k = 0; k < CH_NUM; k++) begin
        if (acc_eop && int'(grant) == k && pkt_cnt[k] != CNT_MAX)
          pkt_cnt[k] <= pkt_cnt[k] + 1'b1;
      end
    end
  end

  // Flatten per-channel counters onto the output bus.
  always_comb begin
    pkt_cnt_o = '0;
    for (int k = 0; k < CH_NUM; k++) pkt_cnt_o[k*CNT_W +: CNT_W] = pkt_cnt[k];
  end

endmodule

// File: tb/tb_mx_pkt_tx_mux.sv
// Purpose: directed bench for mx_pkt_tx_mux (RR instance with 4-bit counters, PRIO instance).
// Latency: sources advance one cycle after each observed transfer.
// Backpressure: source models follow the ready of the instance selected by use_pr.
module tb_mx_pkt_tx_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] ch_data;
  logic [1:0]   ch_sop, ch_eop, ch_val, ch_en;
  logic [5:0]   ch_empty;
  logic         tx_ready, cnt_clr;

  logic [1:0]  rdy_rr, rdy_pr;
  logic [63:0] tx_dat_rr, tx_dat_pr;
  logic [2:0]  tx_emp_rr, tx_emp_pr;
  logic        tx_sop_rr, tx_eop_rr, tx_val_rr, tx_sop_pr, tx_eop_pr, tx_val_pr;
  logic [7:0]  pkt_rr;
  logic [63:0] pkt_pr;
  logic [3:0]  drop_rr;
  logic [31:0] drop_pr;
  logic        cur_rr, busy_rr, cur_pr, busy_pr;

  mx_pkt_tx_mux #(.CH_NUM(2), .DATA_W(64), .ARB_MODE("RR"), .CNT_W(4)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n), .ch_data_i(ch_data), .ch_sop_i(ch_sop), .ch_eop_i(ch_eop),
    .ch_val_i(ch_val), .ch_empty_i(ch_empty), .ch_ready_o(rdy_rr), .ch_en_i(ch_en),
    .tx_data_o(tx_dat_rr), .tx_empty_o(tx_emp_rr), .tx_sop_o(tx_sop_rr), .tx_eop_o(tx_eop_rr),
    .tx_val_o(tx_val_rr), .tx_ready_i(tx_ready), .cnt_clr_i(cnt_clr), .pkt_cnt_o(pkt_rr),
    .drop_cnt_o(drop_rr), .cur_ch_o(cur_rr), .busy_o(busy_rr));

  mx_pkt_tx_mux #(.CH_NUM(2), .DATA_W(64), .ARB_MODE("PRIO"), .CNT_W(32)) dut_pr (
    .clk_i(clk), .rst_n_i(rst_n), .ch_data_i(ch_data), .ch_sop_i(ch_sop), .ch_eop_i(ch_eop),
    .ch_val_i(ch_val), .ch_empty_i(ch_empty), .ch_ready_o(rdy_pr), .ch_en_i(ch_en),
    .tx_data_o(tx_dat_pr), .tx_empty_o(tx_emp_pr), .tx_sop_o(tx_sop_pr), .tx_eop_o(tx_eop_pr),
    .tx_val_o(tx_val_pr), .tx_ready_i(tx_ready), .cnt_clr_i(cnt_clr), .pkt_cnt_o(pkt_pr),
    .drop_cnt_o(drop_pr), .cur_ch_o(cur_pr), .busy_o(busy_pr));

  int n_cmp = 0;
  int n_err = 0;

  // Source model state per channel: word index, packet index, packets left, packet length.
  int w [2];
  int p [2];
  int left [2];
  int len [2];
  bit auto_src, tgl, use_pr, clr_arm, clr_fired, hold;
  logic [66:0] hold_vec;
  int stab_err, ch1_hits, cyc;
  logic [3:0] s_cnt0;

  // Output log.
  logic [63:0] log_dat [64];
  logic        log_sop [64];
  logic        log_eop [64];
  logic [2:0]  log_emp [64];
  int          log_cyc [64];
  int          nlog;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int k, input int pk, input int wd);
    return {40'd0, 8'(k), 8'(pk), 8'(wd)};
  endfunction

  task automatic drive_src();
    for (int k = 0; k < 2; k++) begin
      ch_val[k] = (left[k] > 0);
      ch_sop[k] = (w[k] == 0);
      ch_eop[k] = (w[k] == len[k]-1);
      ch_data[k*64 +: 64] = mk(k, p[k], w[k]);
      ch_empty[k*3 +: 3]  = (w[k] == len[k]-1) ? 3'd3 : 3'd0;
    end
  endtask

  // One clock: observe at negedge, then advance sources after the rising edge.
  task automatic cycle();
    logic [1:0] rdy, xf;
    logic v, s, e;
    logic [63:0] d;
    logic [2:0] em;
    @(negedge clk);
    rdy = use_pr ? rdy_pr : rdy_rr;
    v   = use_pr ? tx_val_pr : tx_val_rr;
    s   = use_pr ? tx_sop_pr : tx_sop_rr;
    e   = use_pr ? tx_eop_pr : tx_eop_rr;
    d   = use_pr ? tx_dat_pr : tx_dat_rr;
    em  = use_pr ? tx_emp_pr : tx_emp_rr;
    s_cnt0 = pkt_rr[3:0];
    if (hold && ({v, s, e, d} != hold_vec)) stab_err++;
    hold     = v && !tx_ready;
    hold_vec = {v, s, e, d};
    if (v && tx_ready && nlog < 64) begin
      log_dat[nlog] = d; log_sop[nlog] = s; log_eop[nlog] = e;
      log_emp[nlog] = em; log_cyc[nlog] = cyc;
      nlog++;
    end
    if (use_pr && left[0] > 0 && rdy[1]) ch1_hits++;
    xf = ch_val & rdy;
    if (clr_arm && xf[0] && ch_eop[0] && pkt_rr[3:0] == 4'd5) begin
      cnt_clr = 1'b1; clr_arm = 1'b0; clr_fired = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
    cnt_clr = 1'b0;
    if (auto_src) begin
      for (int k = 0; k < 2; k++) begin
        if (xf[k]) begin
          if (w[k] == len[k]-1) begin w[k] = 0; p[k]++; left[k]--; end
          else w[k]++;
        end
      end
      drive_src();
    end
    if (tgl) tx_ready = !tx_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin w[k] = 0; p[k] = 0; end
    drive_src();
    hold = 1'b0; nlog = 0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int i = 0;
    while (nlog < n && i < budget) begin cycle(); i++; end
    chk(tag, 64'(nlog), 64'(n));
  endtask

  initial begin
    int bad, ferr, gerr, i, j;
    rst_n = 1'b0; tx_ready = 1'b1; cnt_clr = 1'b0; ch_en = 2'b11;
    auto_src = 1'b1; tgl = 1'b0; use_pr = 1'b0; clr_arm = 1'b0; clr_fired = 1'b0;
    stab_err = 0; ch1_hits = 0; cyc = 0; nlog = 0; hold = 1'b0; hold_vec = '0; s_cnt0 = '0;
    for (int k = 0; k < 2; k++) begin left[k] = 0; len[k] = 3; end

    // Reset state.
    do_reset();
    chk("rst_tx_val", 64'(tx_val_rr), 64'd0);
    chk("rst_tx_data", tx_dat_rr, 64'd0);
    chk("rst_busy", 64'(busy_rr), 64'd0);
    chk("rst_cur_ch", 64'(cur_rr), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_rr), 64'd0);
    chk("rst_drop_cnt", 64'(drop_rr), 64'd0);
    chk("rst_ready", 64'(rdy_rr), 64'd0);

    // Round robin: ch0,ch1,ch0,ch1, 3 words each, one idle cycle between packets.
    left[0] = 2; left[1] = 2; len[0] = 3; len[1] = 3;
    do_reset();
    wait_log("rr_timeout", 12, 200);
    ferr = 0; gerr = 0;
    for (int k = 0; k < 12; k++) begin
      j = k / 3;
      chk("rr_word", log_dat[k], mk(j % 2, j / 2, k % 3));
      if (log_sop[k] != (k % 3 == 0) || log_eop[k] != (k % 3 == 2)) ferr++;
      if (k > 0 && k % 3 == 0 && log_cyc[k] - log_cyc[k-1] != 2) gerr++;
    end
    chk("rr_framing", 64'(ferr), 64'd0);
    chk("rr_gap", 64'(gerr), 64'd0);
    chk("rr_pkt_cnt", 64'(pkt_rr), 64'h22);

    // Fixed priority: ch0 keeps winning while it offers packets.
    use_pr = 1'b1; ch1_hits = 0;
    left[0] = 4; left[1] = 2;
    do_reset();
    wait_log("prio_timeout", 12, 200);
    bad = 0;
    for (int k = 0; k < 12; k++) if (log_dat[k][23:16] != 8'd0) bad++;
    chk("prio_ch0_only", 64'(bad), 64'd0);
    chk("prio_ch1_ready", 64'(ch1_hits), 64'd0);
    chk("prio_cnt1", pkt_pr[63:32], 64'd0);
    chk("prio_cnt0", pkt_pr[31:0], 64'd4);
    use_pr = 1'b0;

    // Output backpressure toggling every cycle during a 4-word packet.
    left[0] = 1; left[1] = 0; len[0] = 4;
    do_reset();
    stab_err = 0; tx_ready = 1'b1; tgl = 1'b1;
    wait_log("bp_timeout", 4, 100);
    repeat (6) cycle();
    tgl = 1'b0; tx_ready = 1'b1;
    chk("bp_words", 64'(nlog), 64'd4);
    for (int k = 0; k < 4; k++) chk("bp_word", log_dat[k], mk(0, 0, k));
    chk("bp_sop", 64'(log_sop[0]), 64'd1);
    chk("bp_eop", 64'(log_eop[3]), 64'd1);
    chk("bp_empty", 64'(log_emp[3]), 64'd3);
    chk("bp_stable", 64'(stab_err), 64'd0);

    // Orphan word on ch1 while idle.
    left[0] = 0; left[1] = 0;
    do_reset();
    auto_src = 1'b0;
    ch_val = 2'b10; ch_sop = 2'b00; ch_eop = 2'b00;
    @(negedge clk);
    chk("orph_ready", 64'(rdy_rr), 64'h2);
    @(posedge clk); #1;
    ch_val = 2'b00;
    repeat (4) cycle();
    chk("orph_drop", 64'(drop_rr), 64'd1);
    chk("orph_no_out", 64'(nlog), 64'd0);
    auto_src = 1'b1;

    // Counter clear colliding with the 6th eop, then saturation at 15.
    len[0] = 1; len[1] = 1; left[0] = 6; left[1] = 0;
    do_reset();
    clr_arm = 1'b1; clr_fired = 1'b0; i = 0;
    while (!clr_fired && i < 100) begin cycle(); i++; end
    chk("clr_fired", 64'(clr_fired), 64'd1);
    cycle();
    chk("clr_cnt0", 64'(s_cnt0), 64'd0);
    left[0] = 16; drive_src();
    i = 0;
    while (left[0] > 0 && i < 200) begin cycle(); i++; end
    repeat (3) cycle();
    chk("sat_cnt0", 64'(pkt_rr[3:0]), 64'd15);

    // Reset in the middle of a packet, then a complete fresh packet.
    len[0] = 4; left[0] = 1; left[1] = 0;
    do_reset();
    wait_log("mrst_pre_timeout", 2, 50);
    rst_n = 1'b0;
    w[0] = 0; p[0] = 1; left[0] = 1;
    drive_src();
    @(posedge clk); #1;
    chk("mrst_tx_val", 64'(tx_val_rr), 64'd0);
    chk("mrst_tx_sop", 64'(tx_sop_rr), 64'd0);
    chk("mrst_tx_data", tx_dat_rr, 64'd0);
    chk("mrst_busy", 64'(busy_rr), 64'd0);
    rst_n = 1'b1; nlog = 0; hold = 1'b0;
    wait_log("mrst_timeout", 4, 50);
    repeat (4) cycle();
    chk("mrst_words", 64'(nlog), 64'd4);
    for (int k = 0; k < 4; k++) chk("mrst_word", log_dat[k], mk(0, 1, k));
    chk("mrst_sop", 64'(log_sop[0]), 64'd1);
    chk("mrst_eop", 64'(log_eop[3]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mx_pkt_tx_mux.md
MX_PKT_TX_MUX -- requirements
Module: mx_pkt_tx_mux

Interface
REQ-001 Parameter CH_NUM, default 2: number of packet source channels, range 2..8.
REQ-002 Parameter DATA_W, default 64: stream data width in bits, a multiple of 8.
REQ-003 Parameter EMPTY_W, default $clog2(DATA_W/8): width of the empty-bytes field.
REQ-004 Parameter ARB_MODE, default "RR": "RR" selects round-robin, "PRIO" selects fixed priority (lowest index wins).
REQ-005 Parameter CNT_W, default 32: statistics counter width.
REQ-006 Clock and reset: single clock clk_i; reset rst_n_i is synchronous and active-low.
REQ-007 clk_i  in  1  156.25 MHz system clock.
REQ-008 rst_n_i  in  1  synchronous active-low reset.
REQ-009 ch_data_i  in  CH_NUM*DATA_W  per-channel data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 ch_sop_i / ch_eop_i / ch_val_i  in  CH_NUM each  per-channel start-of-packet, end-of-packet and valid.
REQ-011 ch_empty_i  in  CH_NUM*EMPTY_W  per-channel empty bytes, meaningful on eop only.
REQ-012 ch_ready_o  out  CH_NUM  per-channel ready.
REQ-013 ch_en_i  in  CH_NUM  channel enable mask from nic control.
REQ-014 tx_data_o / tx_empty_o  out  DATA_W / EMPTY_W  muxed output data and empty bytes.
REQ-015 tx_sop_o / tx_eop_o / tx_val_o  out  1 each  output framing and valid.
REQ-016 tx_ready_i  in  1  downstream (PHY tx path) ready.
REQ-017 cnt_clr_i  in  1  synchronous clear of all counters.
REQ-018 pkt_cnt_o  out  CH_NUM*CNT_W  per-channel count of forwarded packets.
REQ-019 drop_cnt_o  out  CNT_W  count of dropped orphan words (all channels).
REQ-020 cur_ch_o  out  $clog2(CH_NUM)  currently granted channel; busy_o  out  1  high in state PKT.

Function
REQ-021 Handshake: a word transfers on any interface in a cycle where val and ready are both high; valid, once asserted, is held with stable data until it transfers.
REQ-022 FSM states: IDLE, PKT.
REQ-023 IDLE: eligible channels are those with ch_val_i & ch_sop_i & ch_en_i high; if any exist, latch the grant and go to PKT on the next edge; ch_ready_o is 0 for eligible channels in IDLE.
REQ-024 Grant selection in "PRIO" mode: the lowest-index eligible channel.
REQ-025 Grant selection in "RR" mode: the first eligible channel searching upward, with wrap, from last_grant+1; last_grant resets to CH_NUM-1, so channel 0 is the first candidate.
REQ-026 Orphan drop in IDLE: an enabled channel presenting ch_val_i=1, ch_sop_i=0 sees ch_ready_o=1; the word is discarded and drop_cnt_o increments by the number of such channels in that cycle.
REQ-027 PKT ready: ch_ready_o[grant] = !tx_val_o | tx_ready_i; all other channels see ready 0.
REQ-028 PKT output register: an accepted word is registered into the tx_* outputs, giving 1-cycle latency from input transfer to tx_val_o.
REQ-029 PKT exit: on transfer of the eop word from the granted channel, go to IDLE; this enforces a minimum gap of 1 cycle between packets.
REQ-030 An sop seen mid-packet on the granted channel is forwarded unchanged; framing errors are not corrected.
REQ-031 Deasserting ch_en_i mid-packet does not abort the packet; the channel loses eligibility from the next IDLE.
REQ-032 Single-word packet (sop and eop together): IDLE -> PKT -> IDLE; last_grant updates on grant.
REQ-033 tx_val_o clears on an output transfer when no new word is accepted in the same cycle.
REQ-034 pkt_cnt_o[k] increments on the eop transfer from channel k and saturates at all-ones.
REQ-035 drop_cnt_o saturates at all-ones.
REQ-036 cnt_clr_i has priority over a simultaneous increment; the counter becomes 0.

Reset
REQ-037 rst_n_i low at a clock edge forces: state IDLE, last_grant=CH_NUM-1, tx_val_o/tx_sop_o/tx_eop_o=0, tx_data_o/tx_empty_o=0, ch_ready_o=0, all counters 0, cur_ch_o=0, busy_o=0.
REQ-038 Reset mid-packet discards the partial packet with no eop emitted; the first cycle after release is IDLE.

Verification
REQ-039 RR, CH_NUM=2, both channels continuously offer 3-word packets, tx_ready_i=1 -> output order ch0,ch1,ch0,ch1; each packet exactly 3 words; 1 idle cycle between packets; pkt_cnt_o = {2,2} after 4 packets.
REQ-040 PRIO, same stimulus -> only ch0 packets are output; ch1 ready stays 0; pkt_cnt_o[1]=0.
REQ-041 tx_ready_i toggling 1,0,1,0 during a 4-word packet -> no word lost or duplicated; tx_* held stable while tx_ready_i=0; data matches input order.
REQ-042 Orphan word (val=1, sop=0) on ch1 in IDLE -> ch_ready_o[1]=1 for that cycle; drop_cnt_o=1; no output produced.
REQ-043 cnt_clr_i asserted in the same cycle as an eop transfer on ch0, with pkt_cnt_o[0]=5 -> pkt_cnt_o[0]=0 next cycle; with CNT_W=4 and 16 packets -> count holds at 15.
REQ-044 rst_n_i low for 1 cycle in the middle of a packet -> all outputs take their reset values; the next packet from ch0 is output complete, starting with sop.
